// File: rtl/tick_timer.sv
// Tick generator: base tick every max(div,1) enabled cycles, sub tick every SUB base ticks, sq toggles per sub tick.
// Optional fractional dithering of the base period is built when TICK_TIMER_FRAC_EN is defined.
module tick_timer #(
   parameter int DIV_W   = 16,
`ifdef TICK_TIMER_FRAC_EN
   parameter int DEF_DIV = 32,
`else
   parameter int DEF_DIV = 33,
`endif
   parameter int SUB     = 16
`ifdef TICK_TIMER_FRAC_EN
   ,
   parameter int FRAC_W   = 8,
   parameter int DEF_FRAC = 141
`endif
) (
   input  logic             osc_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             div_ld,
   input  logic [DIV_W-1:0] div_in,
`ifdef TICK_TIMER_FRAC_EN
   input  logic [FRAC_W-1:0] frac_in,
`endif
   output logic             tick,
   output logic             tick_sub,
   output logic             sq
);

   localparam int SUB_W = $clog2(SUB);

   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic [DIV_W-1:0] div_sh_q, div_sh_d;
   logic             sh_vld_q, sh_vld_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
   logic             sq_q, sq_d;
   logic             tick_q, tick_d;
   logic             tick_sub_q, tick_sub_d;
   logic [DIV_W-1:0] p_cur, p_ld, p_nxt, div_nxt;
`ifdef TICK_TIMER_FRAC_EN
   logic [FRAC_W-1:0] facc_q, facc_d;
   logic [FRAC_W-1:0] frac_act_q, frac_act_d;
   logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
   logic [FRAC_W-1:0] frac_nxt;
   logic              carry;
`endif

   always_comb begin
      div_act_d  = div_act_q;
      div_sh_d   = div_sh_q;
      sh_vld_d   = sh_vld_q;
      cnt_d      = cnt_q;
      sub_cnt_d  = sub_cnt_q;
      sq_d       = sq_q;
      tick_d     = 1'b0;
      tick_sub_d = 1'b0;
      p_cur      = (div_act_q == '0) ? DIV_W'(1) : div_act_q;
      p_ld       = (div_in == '0) ? DIV_W'(1) : div_in;
      // A load strobe coincident with the terminal count beats any older shadow value.
      div_nxt    = div_ld ? div_in : (sh_vld_q ? div_sh_q : div_act_q);
      p_nxt      = (div_nxt == '0) ? DIV_W'(1) : div_nxt;
`ifdef TICK_TIMER_FRAC_EN
      facc_d     = facc_q;
      frac_act_d = frac_act_q;
      frac_sh_d  = frac_sh_q;
      frac_nxt   = div_ld ? frac_in : (sh_vld_q ? frac_sh_q : frac_act_q);
      carry      = 1'b0;
`endif
      if (clr) begin
         cnt_d     = p_cur - DIV_W'(1);
         sub_cnt_d = '0;
`ifdef TICK_TIMER_FRAC_EN
         facc_d    = '0;
`endif
      end else if (!en) begin
         if (div_ld) begin
            div_act_d = div_in;
            sh_vld_d  = 1'b0;
            cnt_d     = p_ld - DIV_W'(1);
`ifdef TICK_TIMER_FRAC_EN
            frac_act_d = frac_in;
`endif
         end
      end else if (cnt_q == '0) begin
         tick_d    = 1'b1;
         div_act_d = div_nxt;
         sh_vld_d  = 1'b0;
`ifdef TICK_TIMER_FRAC_EN
         {carry, facc_d} = {1'b0, facc_q} + {1'b0, frac_act_q};
         frac_act_d      = frac_nxt;
         cnt_d           = carry ? p_nxt : p_nxt - DIV_W'(1);
`else
         cnt_d           = p_nxt - DIV_W'(1);
`endif
         if (sub_cnt_q == SUB_W'(SUB - 1)) begin
            sub_cnt_d  = '0;
            tick_sub_d = 1'b1;
            sq_d       = ~sq_q;
         end else begin
            sub_cnt_d = sub_cnt_q + SUB_W'(1);
         end
      end else begin
         cnt_d = cnt_q - DIV_W'(1);
         if (div_ld) begin
            div_sh_d = div_in;
            sh_vld_d = 1'b1;
`ifdef TICK_TIMER_FRAC_EN
            frac_sh_d = frac_in;
`endif
         end
      end
   end

   always_ff @(posedge osc_clk) begin
      if (rst) begin
         div_act_q  <= DIV_W'(DEF_DIV);
         div_sh_q   <= '0;
         sh_vld_q   <= 1'b0;
         cnt_q      <= DIV_W'(DEF_DIV - 1);
         sub_cnt_q  <= '0;
         sq_q       <= 1'b0;
         tick_q     <= 1'b0;
         tick_sub_q <= 1'b0;
`ifdef TICK_TIMER_FRAC_EN
         facc_q     <= '0;
         frac_act_q <= FRAC_W'(DEF_FRAC);
         frac_sh_q  <= '0;
`endif
      end else begin
         div_act_q  <= div_act_d;
         div_sh_q   <= div_sh_d;
         sh_vld_q   <= sh_vld_d;
         cnt_q      <= cnt_d;
         sub_cnt_q  <= sub_cnt_d;
         sq_q       <= sq_d;
         tick_q     <= tick_d;
         tick_sub_q <= tick_sub_d;
`ifdef TICK_TIMER_FRAC_EN
         facc_q     <= facc_d;
         frac_act_q <= frac_act_d;
         frac_sh_q  <= frac_sh_d;
`endif
      end
   end

   assign tick     = tick_q;
   assign tick_sub = tick_sub_q;
   assign sq       = sq_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer; cycle c means the output seen just after the c-th enabled edge after reset release.
module tb_tick_timer;

   logic        osc_clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        div_ld = 1'b0;
   logic [15:0] div_in = '0;
`ifdef TICK_TIMER_FRAC_EN
   logic [7:0]  frac_in = '0;
`endif
   logic        tick, tick_sub, sq;

   int checks = 0;
   int failures = 0;

   tick_timer dut (
      .osc_clk (osc_clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .div_ld  (div_ld),
      .div_in  (div_in),
`ifdef TICK_TIMER_FRAC_EN
      .frac_in (frac_in),
`endif
      .tick    (tick),
      .tick_sub(tick_sub),
      .sq      (sq)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic step();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic do_reset(input logic en_v);
      rst = 1'b1; en = 1'b0; clr = 1'b0; div_ld = 1'b0; div_in = '0;
`ifdef TICK_TIMER_FRAC_EN
      frac_in = '0;
`endif
      repeat (3) step();
      rst = 1'b0;
      en  = en_v;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1;
      repeat (2) step();
      checks++;
      if ({tick, tick_sub, sq} !== 3'b000) begin
         failures++;
         $display("FAIL reset_hold: got %b%b%b want 000", tick, tick_sub, sq);
      end
      do_reset(1'b0);
      for (int c = 1; c <= 40; c++) begin
         step();
         checks++;
         if ({tick, tick_sub, sq} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle c=%0d: got %b%b%b want 000", c, tick, tick_sub, sq);
         end
      end
   endtask

   task automatic test_basic();
      logic et, es, eq;
      do_reset(1'b1);
      for (int c = 1; c <= 530; c++) begin
         step();
         et = (c % 33 == 0);
         es = (c == 528);
         eq = (c >= 528);
         checks++;
         if ({tick, tick_sub, sq} !== {et, es, eq}) begin
            failures++;
            $display("FAIL basic c=%0d: got %b%b%b want %b%b%b", c, tick, tick_sub, sq, et, es, eq);
         end
      end
   endtask

   task automatic test_load();
      logic et;
      do_reset(1'b1);
      for (int c = 1; c <= 50; c++) begin
         if (c == 10) begin div_ld = 1'b1; div_in = 16'd5; end
         step();
         div_ld = 1'b0;
         et = (c == 33 || c == 38 || c == 43 || c == 48);
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL load c=%0d: tick got %b want %b", c, tick, et);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic et;
      do_reset(1'b1);
      for (int c = 1; c <= 60; c++) begin
         if (c == 5)  begin div_ld = 1'b1; div_in = 16'd7; end
         if (c == 20) begin div_ld = 1'b1; div_in = 16'd4; end
         if (c == 41) begin div_ld = 1'b1; div_in = 16'd6; end
         step();
         div_ld = 1'b0;
         et = (c == 33 || c == 37 || c == 41 || c == 47 || c == 53 || c == 59);
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL back_to_back c=%0d: tick got %b want %b", c, tick, et);
         end
      end
   endtask

   task automatic test_div_zero();
      logic es, eq;
      do_reset(1'b0);
      div_ld = 1'b1; div_in = 16'd0;
      step();
      div_ld = 1'b0;
      checks++;
      if (tick !== 1'b0) begin
         failures++;
         $display("FAIL div0_disabled: tick got %b want 0", tick);
      end
      en = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         es = (c % 16 == 0);
         eq = (c >= 16 && c < 32);
         checks++;
         if ({tick, tick_sub, sq} !== {1'b1, es, eq}) begin
            failures++;
            $display("FAIL div0 c=%0d: got %b%b%b want 1%b%b", c, tick, tick_sub, sq, es, eq);
         end
      end
   endtask

   task automatic test_enable();
      logic et, es, eq;
      do_reset(1'b1);
      for (int c = 1; c <= 540; c++) begin
         en = !(c >= 50 && c <= 56);
         step();
         if (c < 50) et = (c % 33 == 0);
         else        et = (c > 56) && ((c - 7) % 33 == 0);
         es = (c == 535);
         eq = (c >= 535);
         checks++;
         if ({tick, tick_sub, sq} !== {et, es, eq}) begin
            failures++;
            $display("FAIL enable c=%0d: got %b%b%b want %b%b%b", c, tick, tick_sub, sq, et, es, eq);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_clr();
      logic et, es, eq;
      do_reset(1'b1);
      for (int c = 1; c <= 630; c++) begin
         clr = (c == 33 || c == 100);
         step();
         clr = 1'b0;
         et = (c == 66 || c == 99) || (c >= 133 && (c - 133) % 33 == 0);
         es = (c == 628);
         eq = (c >= 628);
         checks++;
         if ({tick, tick_sub, sq} !== {et, es, eq}) begin
            failures++;
            $display("FAIL clr c=%0d: got %b%b%b want %b%b%b", c, tick, tick_sub, sq, et, es, eq);
         end
      end
   endtask

   task automatic test_rst_pending();
      logic et;
      do_reset(1'b1);
      for (int c = 1; c <= 33; c++) begin
         if (c == 10) begin div_ld = 1'b1; div_in = 16'd5; end
         if (c == 33) rst = 1'b1;
         step();
         div_ld = 1'b0;
      end
      checks++;
      if ({tick, tick_sub, sq} !== 3'b000) begin
         failures++;
         $display("FAIL rst_mid: got %b%b%b want 000", tick, tick_sub, sq);
      end
      rst = 1'b0;
      for (int c = 1; c <= 70; c++) begin
         step();
         et = (c == 33 || c == 66);
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL rst_pending c=%0d: tick got %b want %b", c, tick, et);
         end
      end
   endtask

`ifdef TICK_TIMER_FRAC_EN
   task automatic wait_tick(output int dt, output bit timed_out);
      dt = 0;
      timed_out = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (tick === 1'b1) begin
            dt = i;
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_frac();
      int ntick, t1, tlast, last, n33, dt;
      bit to;
      ntick = 0; t1 = 0; tlast = 0; last = 0; n33 = 0;
      do_reset(1'b1);
      for (int c = 1; c <= 9000 && ntick < 257; c++) begin
         step();
         if (tick === 1'b1) begin
            ntick++;
            if (ntick == 1) t1 = c;
            else if (c - last == 33) n33++;
            last = c;
            tlast = c;
         end
      end
      checks++;
      if (ntick !== 257) begin
         failures++;
         $display("FAIL frac_ticks: got %0d want 257", ntick);
      end
      checks++;
      if (t1 !== 32) begin
         failures++;
         $display("FAIL frac_first: got %0d want 32", t1);
      end
      checks++;
      if (tlast - t1 !== 8333) begin
         failures++;
         $display("FAIL frac_total: got %0d want 8333", tlast - t1);
      end
      checks++;
      if (n33 !== 141) begin
         failures++;
         $display("FAIL frac_long: got %0d want 141", n33);
      end
      repeat (5) step();
      div_ld = 1'b1; div_in = 16'd10; frac_in = 8'd0;
      step();
      div_ld = 1'b0;
      wait_tick(dt, to);
      checks++;
      if (to || dt + 6 !== 32) begin
         failures++;
         $display("FAIL frac_ld_complete: got %0d want 32", dt + 6);
      end
      wait_tick(dt, to);
      checks++;
      if (to || dt !== 11) begin
         failures++;
         $display("FAIL frac_ld_carry: got %0d want 11", dt);
      end
      for (int k = 0; k < 2; k++) begin
         wait_tick(dt, to);
         checks++;
         if (to || dt !== 10) begin
            failures++;
            $display("FAIL frac_ld_new k=%0d: got %0d want 10", k, dt);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef TICK_TIMER_FRAC_EN
      test_frac();
`else
      test_basic();
      test_load();
      test_back_to_back();
      test_div_zero();
      test_enable();
      test_clr();
      test_rst_pending();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
